// File: rtl/uart_sample_framer.sv
// Decimated, frame-coherent capture of four sample channels, serialised as
// 5-byte "CH<n>"+MSB+LSB records through a tx_start/tx_busy byte handshake.
module uart_sample_framer #(
  parameter int unsigned DECIMATE = 96,
  parameter logic [3:0]  CH_MASK  = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_clk,
  input  logic signed [15:0] sample_in0,
  input  logic signed [15:0] sample_in1,
  input  logic signed [15:0] sample_in2,
  input  logic signed [15:0] sample_in3,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               frame_active,
  output logic [7:0]         overrun_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT} state_t;

  function automatic logic [1:0] first_enabled();
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (CH_MASK[i]) r = 2'(i);
    return r;
  endfunction

  // {found, index} of the lowest enabled channel above c.
  function automatic logic [2:0] next_enabled(input logic [1:0] c);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) if (i > int'(c) && CH_MASK[i]) r = {1'b1, 2'(i)};
    return r;
  endfunction

  localparam logic [1:0]  FIRST_CH = first_enabled();
  localparam logic [15:0] DEC_LAST = 16'(DECIMATE - 1);

  state_t             state_q, state_d;
  logic               prev_sclk_q, prev_sclk_d;
  logic [15:0]        dec_cnt_q, dec_cnt_d;
  logic signed [15:0] snap_q [4];
  logic signed [15:0] snap_d [4];
  logic [1:0]         ch_q, ch_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               frame_active_q, frame_active_d;
  logic [7:0]         overrun_q, overrun_d;

  logic               sclk_edge;
  logic               capture_opp;
  logic [7:0]         cur_byte;
  logic [2:0]         nxt_ch;

  always_comb begin
    case (byte_idx_q)
      3'd0:    cur_byte = 8'h43;
      3'd1:    cur_byte = 8'h48;
      3'd2:    cur_byte = 8'h30 + {6'd0, ch_q};
      3'd3:    cur_byte = snap_q[ch_q][15:8];
      default: cur_byte = snap_q[ch_q][7:0];
    endcase
  end

  // NOTE: every _d gets its hold value first so no path through this block
  // leaves a signal unassigned, which is what keeps latches from being inferred.
  always_comb begin
    state_d        = state_q;
    prev_sclk_d    = sample_clk;
    dec_cnt_d      = dec_cnt_q;
    snap_d         = snap_q;
    ch_d           = ch_q;
    byte_idx_d     = byte_idx_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    overrun_d      = overrun_q;
    nxt_ch         = next_enabled(ch_q);
    sclk_edge      = sample_clk & ~prev_sclk_q;
    capture_opp    = sclk_edge && (dec_cnt_q == 16'd0);

    if (sclk_edge) dec_cnt_d = (dec_cnt_q >= DEC_LAST) ? 16'd0 : dec_cnt_q + 16'd1;

    if (capture_opp && CH_MASK != 4'b0000) begin
      if (state_q == S_IDLE) begin
        snap_d     = '{sample_in0, sample_in1, sample_in2, sample_in3};
        ch_d       = FIRST_CH;
        byte_idx_d = 3'd0;
        state_d    = S_SEND;
      end else if (overrun_q != 8'hFF) begin
        overrun_d = overrun_q + 8'd1;
      end
    end

    case (state_q)
      S_SEND: if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = cur_byte;
        state_d    = S_GUARD;
      end
      // uart_tx needs a cycle to raise tx_busy after the start pulse.
      S_GUARD: state_d = S_WAIT;
      S_WAIT: if (!tx_busy) begin
        if (byte_idx_q != 3'd4) begin
          byte_idx_d = byte_idx_q + 3'd1;
          state_d    = S_SEND;
        end else if (nxt_ch[2]) begin
          ch_d       = nxt_ch[1:0];
          byte_idx_d = 3'd0;
          state_d    = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    frame_active_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      prev_sclk_q    <= 1'b0;
      dec_cnt_q      <= 16'd0;
      ch_q           <= 2'd0;
      byte_idx_q     <= 3'd0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      frame_active_q <= 1'b0;
      overrun_q      <= 8'h00;
      // NOTE: the snapshot is a small flop array with a defined reset value,
      // not a RAM, so clearing it here costs nothing structural.
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      prev_sclk_q    <= prev_sclk_d;
      dec_cnt_q      <= dec_cnt_d;
      ch_q           <= ch_d;
      byte_idx_q     <= byte_idx_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      frame_active_q <= frame_active_d;
      overrun_q      <= overrun_d;
      for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
    end
  end

  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign frame_active  = frame_active_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_uart_sample_framer.sv
// Scoreboard bench for uart_sample_framer: four instances with different
// DECIMATE/CH_MASK, a byte-level uart_tx busy model and per-scenario tasks.
module tb_uart_sample_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [3:0]         sclk;
  logic [3:0]         force_busy;
  logic               model_en;
  logic [3:0]         tx_busy;
  int                 busy_cnt [4];
  logic signed [15:0] din [4];

  logic               tx_start_w [4];
  logic [7:0]         tx_data_w  [4];
  logic               fa_w       [4];
  logic [7:0]         ovr_w      [4];

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [$];
  int         pulses [4];
  logic       prev_start [4];

  uart_sample_framer #(.DECIMATE(1), .CH_MASK(4'hF)) u_full (
    .clk(clk), .rst(rst), .sample_clk(sclk[0]),
    .sample_in0(din[0]), .sample_in1(din[1]), .sample_in2(din[2]), .sample_in3(din[3]),
    .tx_busy(tx_busy[0]), .tx_start(tx_start_w[0]), .tx_data(tx_data_w[0]),
    .frame_active(fa_w[0]), .overrun_count(ovr_w[0]));

  uart_sample_framer #(.DECIMATE(4), .CH_MASK(4'hF)) u_dec4 (
    .clk(clk), .rst(rst), .sample_clk(sclk[1]),
    .sample_in0(din[0]), .sample_in1(din[1]), .sample_in2(din[2]), .sample_in3(din[3]),
    .tx_busy(tx_busy[1]), .tx_start(tx_start_w[1]), .tx_data(tx_data_w[1]),
    .frame_active(fa_w[1]), .overrun_count(ovr_w[1]));

  uart_sample_framer #(.DECIMATE(1), .CH_MASK(4'b0101)) u_m5 (
    .clk(clk), .rst(rst), .sample_clk(sclk[2]),
    .sample_in0(din[0]), .sample_in1(din[1]), .sample_in2(din[2]), .sample_in3(din[3]),
    .tx_busy(tx_busy[2]), .tx_start(tx_start_w[2]), .tx_data(tx_data_w[2]),
    .frame_active(fa_w[2]), .overrun_count(ovr_w[2]));

  uart_sample_framer #(.DECIMATE(1), .CH_MASK(4'b0000)) u_m0 (
    .clk(clk), .rst(rst), .sample_clk(sclk[3]),
    .sample_in0(din[0]), .sample_in1(din[1]), .sample_in2(din[2]), .sample_in3(din[3]),
    .tx_busy(tx_busy[3]), .tx_start(tx_start_w[3]), .tx_data(tx_data_w[3]),
    .frame_active(fa_w[3]), .overrun_count(ovr_w[3]));

  // uart_tx model: busy for 10 cycles after each accepted start pulse.
  for (genvar g = 0; g < 4; g++) begin : g_busy
    assign tx_busy[g] = force_busy[g] | (busy_cnt[g] != 0);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) busy_cnt[i] <= 0;
      else if (tx_start_w[i] && model_en) busy_cnt[i] <= 10;
      else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end

  initial for (int i = 0; i < 4; i++) begin pulses[i] = 0; prev_start[i] = 1'b0; end

  // Scoreboard: every start pulse from any instance pops one expected byte.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tx_start_w[i] === 1'b1) begin
        pulses[i]++;
        checks++;
        if (prev_start[i] === 1'b1) begin
          errors++;
          $display("FAIL start_width dut%0d: tx_start high 2 cycles, required 1", i);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte dut%0d: got %02h, required no transmission", i, tx_data_w[i]);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data_w[i] !== e) begin
            errors++;
            $display("FAIL byte dut%0d: got %02h, required %02h", i, tx_data_w[i], e);
          end
        end
      end
      prev_start[i] = tx_start_w[i];
    end
  end

  task automatic push_frame(input logic [3:0] mask);
    for (int c = 0; c < 4; c++) if (mask[c]) begin
      logic [15:0] v;
      v = din[c];
      exp_q.push_back(8'h43);
      exp_q.push_back(8'h48);
      exp_q.push_back(8'h30 + 8'(c));
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
    end
  endtask

  task automatic pulse(input int i);
    @(negedge clk); sclk[i] = 1'b1;
    @(negedge clk); sclk[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (fa_w[i] === 1'b1 && n < budget) begin @(negedge clk); n++; end
    #1;
    checks++;
    if (fa_w[i] !== 1'b0) begin
      errors++;
      $display("FAIL frame_timeout dut%0d: frame_active=%b after %0d cycles, required 0", i, fa_w[i], budget);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_bytes dut%0d: %0d expected bytes never sent, required 0", i, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = '0; force_busy = '0; model_en = 1'b0;
    for (int c = 0; c < 4; c++) din[c] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_start_w[i] !== 1'b0 || tx_data_w[i] !== 8'h00 || fa_w[i] !== 1'b0 || ovr_w[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_state dut%0d: start=%b data=%02h active=%b ovr=%0d, required 0 0 0 0",
                 i, tx_start_w[i], tx_data_w[i], fa_w[i], ovr_w[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    logic [7:0] ref_bytes [20];
    int first_k, last_k, prev_k, active, npulse;
    logic bad_gap;
    ref_bytes = '{8'h43, 8'h48, 8'h30, 8'h12, 8'h34, 8'h43, 8'h48, 8'h31, 8'hFF, 8'hFE,
                  8'h43, 8'h48, 8'h32, 8'h7F, 8'hFF, 8'h43, 8'h48, 8'h33, 8'h80, 8'h00};
    din[0] = 16'h1234; din[1] = 16'hFFFE; din[2] = 16'h7FFF; din[3] = 16'h8000;
    for (int b = 0; b < 20; b++) exp_q.push_back(ref_bytes[b]);
    first_k = -1; last_k = -1; prev_k = -1; active = 0; npulse = 0; bad_gap = 1'b0;
    @(negedge clk); sclk[0] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      sclk[0] = 1'b0;
      if (fa_w[0] === 1'b1) active++;
      if (tx_start_w[0] === 1'b1) begin
        if (first_k < 0) first_k = k;
        if (prev_k >= 0 && k - prev_k != 3) bad_gap = 1'b1;
        prev_k = k; last_k = k; npulse++;
      end
    end
    checks++;
    if (first_k != 2) begin errors++; $display("FAIL first_pulse: cycle E+%0d, required E+2", first_k); end
    checks++;
    if (last_k != 59) begin errors++; $display("FAIL last_pulse: cycle E+%0d, required E+59", last_k); end
    checks++;
    if (npulse != 20) begin errors++; $display("FAIL pulse_count: %0d, required 20", npulse); end
    checks++;
    if (bad_gap) begin errors++; $display("FAIL pulse_spacing: gap other than 3 seen, required 3"); end
    checks++;
    if (active != 60) begin errors++; $display("FAIL active_len: %0d cycles, required 60", active); end
    wait_done(0, 50);
  endtask

  task automatic test_atomic_snapshot();
    din[0] = 16'hA5C3; din[1] = 16'h0102; din[2] = 16'h8001; din[3] = 16'h7F00;
    push_frame(4'hF);
    @(negedge clk); sclk[0] = 1'b1;
    @(negedge clk); sclk[0] = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) din[c] = '0;
    wait_done(0, 100);
  endtask

  task automatic test_overrun();
    model_en = 1'b1;
    din[0] = 16'h0F0F; din[1] = 16'h1357; din[2] = 16'hFEDC; din[3] = 16'h0001;
    push_frame(4'hF);
    // 14 edges, 20 cycles apart; the frame spans E+1..E+260, so edges 1..13 overrun.
    for (int k = 0; k < 14; k++) begin
      pulse(0);
      repeat (18) @(negedge clk);
    end
    wait_done(0, 400);
    checks++;
    if (ovr_w[0] !== 8'd13) begin errors++; $display("FAIL overrun_count: %0d, required 13", ovr_w[0]); end

    // Hold the frame in SEND and hammer it with edges to reach saturation.
    force_busy[0] = 1'b1;
    din[0] = 16'h2222; din[1] = 16'h3333; din[2] = 16'h4444; din[3] = 16'h5555;
    push_frame(4'hF);
    for (int n = 1; n <= 300; n++) begin
      pulse(0);
      if (n == 242) begin
        checks++;
        if (ovr_w[0] !== 8'd254) begin errors++; $display("FAIL overrun_pre_sat: %0d, required 254", ovr_w[0]); end
      end
    end
    checks++;
    if (ovr_w[0] !== 8'd255) begin errors++; $display("FAIL overrun_saturate: %0d, required 255", ovr_w[0]); end
    force_busy[0] = 1'b0;
    wait_done(0, 400);
    model_en = 1'b0;
  endtask

  task automatic test_decimate();
    int base;
    base = pulses[1];
    for (int e = 0; e < 8; e++) begin
      for (int c = 0; c < 4; c++) din[c] = 16'(e * 256 + c * 17 + 5);
      if (e == 0 || e == 4) push_frame(4'hF);
      pulse(1);
      repeat (80) @(negedge clk);
    end
    wait_done(1, 50);
    checks++;
    if (pulses[1] - base != 40) begin errors++; $display("FAIL decimate_bytes: %0d, required 40", pulses[1] - base); end
    checks++;
    if (ovr_w[1] !== 8'd0) begin errors++; $display("FAIL decimate_overrun: %0d, required 0", ovr_w[1]); end
  endtask

  task automatic test_channel_mask();
    logic saw_active;
    int base2;
    base2 = pulses[2];
    saw_active = 1'b0;
    din[0] = 16'hBEEF; din[1] = 16'h1111; din[2] = 16'hCAFE; din[3] = 16'h2222;
    push_frame(4'b0101);
    @(negedge clk); sclk[2] = 1'b1; sclk[3] = 1'b1;
    @(negedge clk); sclk[2] = 1'b0; sclk[3] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (fa_w[3] === 1'b1) saw_active = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      pulse(3);
      if (fa_w[3] === 1'b1) saw_active = 1'b1;
    end
    wait_done(2, 50);
    checks++;
    if (pulses[2] - base2 != 10) begin errors++; $display("FAIL mask5_bytes: %0d, required 10", pulses[2] - base2); end
    checks++;
    if (pulses[3] != 0 || saw_active) begin
      errors++;
      $display("FAIL mask0_activity: pulses=%0d active_seen=%b, required 0 0", pulses[3], saw_active);
    end
    checks++;
    if (ovr_w[3] !== 8'd0) begin errors++; $display("FAIL mask0_overrun: %0d, required 0", ovr_w[3]); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    din[0] = 16'h0A0B; din[1] = 16'h0C0D; din[2] = 16'h0E0F; din[3] = 16'h1011;
    push_frame(4'hF);
    n = pulses[0] + 7;
    pulse(0);
    for (int k = 0; k < 200 && pulses[0] < n; k++) begin @(negedge clk); #1; end
    checks++;
    if (pulses[0] < n) begin errors++; $display("FAIL mid_frame_timeout: %0d bytes, required 7", pulses[0] - n + 7); end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx_start_w[0] !== 1'b0 || fa_w[0] !== 1'b0 || ovr_w[0] !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: start=%b active=%b ovr=%0d, required 0 0 0", tx_start_w[0], fa_w[0], ovr_w[0]);
    end
    repeat (2) @(negedge clk);
    din[0] = 16'h4321; din[1] = 16'h8765; din[2] = 16'hCBA9; din[3] = 16'h0FED;
    push_frame(4'hF);
    pulse(0);
    wait_done(0, 100);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_atomic_snapshot();
    test_overrun();
    test_decimate();
    test_channel_mask();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
